// File: rtl/stream_uart_emitter_if.sv
// -----------------------------------------------------------------------------
// stream_uart_emitter_if
// Bundle of N_CH parallel byte streams (AXI-stream subset) feeding the UART
// emitter.
//   tdata  [8*N_CH-1:0]  channel c byte at [8c+7:8c]
//   tlast  [N_CH-1:0]    last byte of packet, per channel
//   tvalid [N_CH-1:0]    byte valid, per channel
//   tready [N_CH-1:0]    byte accepted when tvalid & tready, per channel
// Modports: master = stream producer, slave = emitter.
// -----------------------------------------------------------------------------
interface stream_uart_emitter_if #(
  parameter int N_CH = 1
);
  logic [8*N_CH-1:0] tdata;
  logic [N_CH-1:0]   tlast;
  logic [N_CH-1:0]   tvalid;
  logic [N_CH-1:0]   tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/stream_uart_emitter.sv
// -----------------------------------------------------------------------------
// stream_uart_emitter
// Multi-channel byte-stream to UART (8N1) transmitter. Packets from N_CH
// streams are granted round-robin on packet boundaries, buffered in a
// 2**FIFO_AW byte FIFO and shifted out LSB first at CLK_FREQ_HZ/BAUD_RATE
// clocks per bit.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   s_axis           stream bundle (slave modport)
//   o_uart_tx        serial line, idle high, registered
//   o_busy           FIFO non-empty or frame in progress
//   o_fifo_level     bytes currently held in the FIFO (0..2**FIFO_AW)
// -----------------------------------------------------------------------------
module stream_uart_emitter #(
  parameter int CLK_FREQ_HZ = 16_000_000,
  parameter int BAUD_RATE   = 57_600,
  parameter int N_CH        = 1,
  parameter int FIFO_AW     = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  stream_uart_emitter_if.slave   s_axis,
  output logic                   o_uart_tx,
  output logic                   o_busy,
  output logic [FIFO_AW:0]       o_fifo_level
);

  localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W = $clog2(DIV);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------------------------------------------------------------------
  // Round-robin packet arbiter
  // ---------------------------------------------------------------------------
  logic            locked;
  logic [CH_W-1:0] grant;
  logic [CH_W-1:0] last_ptr;
  logic            rr_found;
  logic [CH_W-1:0] rr_pick;
  int              rr_idx;

  logic [FIFO_AW:0]   level;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic [7:0]         push_data;
  tx_state_t          tx_state;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_ptr;
    rr_idx   = 0;
    for (int k = 1; k <= N_CH; k++) begin
      rr_idx = (int'(last_ptr) + k) % N_CH;
      if (!rr_found && s_axis.tvalid[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = CH_W'(rr_idx);
      end
    end
  end

  // Ready depends only on registered state: the lock, the grant and the
  // registered full flag, so there is no combinational path from tvalid.
  always_comb begin
    s_axis.tready = '0;
    if (locked && !fifo_full) s_axis.tready[grant] = 1'b1;
  end

  assign push      = locked && !fifo_full && s_axis.tvalid[grant];
  assign push_data = s_axis.tdata[{grant, 3'b000} +: 8];

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      locked   <= 1'b0;
      grant    <= '0;
      last_ptr <= CH_W'(N_CH - 1);
    end else if (!locked) begin
      if (rr_found) begin
        locked   <= 1'b1;
        grant    <= rr_pick;
        last_ptr <= rr_pick;
      end
    end else if (push && s_axis.tlast[grant]) begin
      // Unlocking here forces the one-cycle bubble between packets.
      locked <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;

  // Level never exceeds DEPTH, so its MSB is set exactly when full.
  assign fifo_full = level[FIFO_AW];
  assign pop       = (tx_state == TX_IDLE) && (level != '0);

  // NOTE: the storage array has no reset; level and pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // 8N1 transmitter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             uart_tx;

  // The line value is set on each state transition so that it is a plain
  // register and each bit cell is exactly DIV cycles long.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state  <= TX_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            shift_reg <= mem[rd_ptr];
            uart_tx   <= 1'b0;
            bit_cnt   <= '0;
            tx_state  <= TX_START;
          end
        end
        TX_START: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            uart_tx  <= shift_reg[0];
            tx_state <= TX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= shift_reg >> 1;
              uart_tx   <= shift_reg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt  <= '0;
            tx_state <= TX_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign o_uart_tx    = uart_tx;
  assign o_fifo_level = level;
  // Both terms are registers, so busy changes only right after a clock edge.
  assign o_busy       = (tx_state != TX_IDLE) || (level != '0);

endmodule

// File: tb/tb_stream_uart_emitter.sv
// -----------------------------------------------------------------------------
// tb_stream_uart_emitter
// Three random-length packet streams drive a 3-channel emitter with a 4-byte
// FIFO at 10 clocks per bit. The expected line byte order is the round-robin
// concatenation of the packets; each frame's start cycle is predicted from the
// acceptance cycle of its byte and the previous frame start. A line decoder
// pops and compares against those queues.
// -----------------------------------------------------------------------------
module tb_stream_uart_emitter;

  localparam int N_CH    = 3;
  localparam int FIFO_AW = 2;
  localparam int DEPTH   = 4;
  localparam int DIV     = 10;
  localparam int FRAME_P = 10 * DIV + 1;
  localparam int N_PKT   = 4;
  localparam int MAX_LEN = 4;

  logic       i_clk;
  logic       i_rst_n;
  logic       uart_tx;
  logic       busy;
  logic [2:0] fifo_level;

  stream_uart_emitter_if #(.N_CH(N_CH)) bus ();

  stream_uart_emitter #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD_RATE  (100_000),
    .N_CH       (N_CH),
    .FIFO_AW    (FIFO_AW)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .s_axis      (bus.slave),
    .o_uart_tx   (uart_tx),
    .o_busy      (busy),
    .o_fifo_level(fifo_level)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Per-channel drive values, packed onto the bus.
  logic [7:0] d [N_CH];
  logic       l [N_CH];
  logic       v [N_CH];

  always_comb begin
    bus.tdata  = '0;
    bus.tlast  = '0;
    bus.tvalid = '0;
    for (int c = 0; c < N_CH; c++) begin
      bus.tdata[8*c +: 8] = d[c];
      bus.tlast[c]        = l[c];
      bus.tvalid[c]       = v[c];
    end
  end

  // Packet model and scoreboard queues.
  logic [7:0] pdat [N_CH][N_PKT][MAX_LEN];
  int         plen [N_CH][N_PKT];
  logic [7:0] exp_q[$];
  int         acc_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_rx = 0;
  int prev_start = -1000;
  int last_end = -10;
  int owner = -1;
  int peak = 0;
  bit abort = 0;
  bit mon_en = 0;
  bit inv_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one packet on channel c, beat by beat, with random mid-packet gaps.
  task automatic send_pkt(input int c, input int p);
    int w;
    int acc_edge;
    for (int b = 0; b < plen[c][p]; b++) begin
      if (abort) return;
      d[c] = pdat[c][p][b];
      l[c] = (b == plen[c][p] - 1);
      v[c] = 1'b1;
      w = 0;
      forever begin
        @(negedge i_clk);
        if (bus.tready[c]) break;
        w++;
        if (w > 3000) begin
          check($sformatf("accept_timeout_ch%0d", c), 0, 1);
          abort = 1;
          v[c] = 1'b0;
          return;
        end
      end
      acc_edge = cyc + 1;
      acc_q.push_back(acc_edge);
      check("bubble_after_packet", (acc_edge == last_end + 1), 0);
      @(posedge i_clk);
      #1;
      if (l[c]) begin
        last_end = acc_edge;
        owner = -1;
      end else begin
        owner = c;
        if ($urandom_range(0, 2) == 0) begin
          v[c] = 1'b0;
          repeat ($urandom_range(1, 3)) #10;
        end
      end
    end
  endtask

  task automatic drive_ch(input int c);
    for (int p = 0; p < N_PKT; p++) send_pkt(c, p);
    v[c] = 1'b0;
  endtask

  // Decode one frame whose start bit was first seen at this negedge.
  task automatic decode_frame();
    int k;
    int a;
    int exp_start;
    logic [7:0] rx;
    k = cyc;
    if (acc_q.size() == 0) begin
      check("frame_without_accept", 1, 0);
      exp_start = k;
    end else begin
      a = acc_q.pop_front();
      exp_start = (prev_start + FRAME_P > a + 1) ? prev_start + FRAME_P : a + 1;
    end
    check("frame_start_cycle", k, exp_start);
    prev_start = k;
    repeat (DIV / 2 - 1) @(negedge i_clk);
    check("start_bit", uart_tx, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge i_clk);
      rx[i] = uart_tx;
    end
    repeat (DIV) @(negedge i_clk);
    check("stop_bit", uart_tx, 1);
    if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
    else check("rx_byte", rx, exp_q.pop_front());
    n_rx++;
  endtask

  initial begin
    forever begin
      @(negedge i_clk);
      if (mon_en && i_rst_n && uart_tx === 1'b0) decode_frame();
    end
  end

  // Per-cycle handshake rules.
  always @(negedge i_clk) begin
    if (inv_en && i_rst_n) begin
      check("tready_onehot0", $onehot0(bus.tready), 1);
      check("tready_while_full", (fifo_level == 3'(DEPTH)) && (bus.tready != '0), 0);
      check("level_bound", (fifo_level <= 3'(DEPTH)), 1);
      if (owner >= 0)
        check("lock_held", ((bus.tready & ~(3'b001 << owner)) == '0), 1);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
  end

  initial begin
    int total;
    int w;
    int low_cnt;
    int s;
    int rx0;
    for (int c = 0; c < N_CH; c++) begin
      d[c] = '0;
      l[c] = 1'b0;
      v[c] = 1'b0;
    end
    i_rst_n = 1'b0;

    // Reset state.
    repeat (3) @(negedge i_clk);
    check("reset_uart_tx", uart_tx, 1);
    check("reset_tready", bus.tready, 0);
    check("reset_level", fifo_level, 0);
    check("reset_busy", busy, 0);
    i_rst_n = 1'b1;

    // Random packets on all channels; line order is strict rotation 0,1,2.
    total = 0;
    for (int c = 0; c < N_CH; c++)
      for (int p = 0; p < N_PKT; p++) begin
        plen[c][p] = $urandom_range(1, MAX_LEN);
        for (int b = 0; b < MAX_LEN; b++) pdat[c][p][b] = 8'($urandom);
      end
    for (int p = 0; p < N_PKT; p++)
      for (int c = 0; c < N_CH; c++)
        for (int b = 0; b < plen[c][p]; b++) begin
          exp_q.push_back(pdat[c][p][b]);
          total++;
        end
    mon_en = 1;
    inv_en = 1;
    @(posedge i_clk);
    #1;
    fork
      drive_ch(0);
      drive_ch(1);
      drive_ch(2);
    join
    w = 0;
    while (n_rx < total && w < 20000 && !abort) begin
      @(negedge i_clk);
      w++;
    end
    check("all_bytes_received", n_rx, total);
    repeat (10) @(negedge i_clk);
    check("drain_level", fifo_level, 0);
    check("drain_busy", busy, 0);
    check("drain_uart_tx", uart_tx, 1);
    check("fifo_peak_level", peak, DEPTH);
    check("accept_queue_empty", acc_q.size(), 0);

    // Reset in the middle of a 0 data bit.
    mon_en = 0;
    d[1] = 8'hA5;
    l[1] = 1'b1;
    v[1] = 1'b1;
    w = 0;
    do begin
      @(negedge i_clk);
      w++;
    end while (!bus.tready[1] && w < 50);
    check("phase2_grant", bus.tready[1], 1);
    @(posedge i_clk);
    #1;
    v[1] = 1'b0;
    l[1] = 1'b0;
    w = 0;
    do begin
      @(negedge i_clk);
      w++;
    end while (uart_tx !== 1'b0 && w < 20);
    check("phase2_frame_started", uart_tx, 0);
    repeat (25) @(negedge i_clk);
    check("phase2_mid_bit1", uart_tx, 0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_reset_uart_tx", uart_tx, 1);
    check("async_reset_tready", bus.tready, 0);
    check("async_reset_level", fifo_level, 0);
    check("async_reset_busy", busy, 0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    low_cnt = 0;
    repeat (150) @(negedge i_clk) if (uart_tx !== 1'b1) low_cnt++;
    check("no_residual_frame", low_cnt, 0);
    check("post_reset_busy", busy, 0);

    // Single 0x55 frame and busy timing.
    prev_start = -1000;
    mon_en = 1;
    pdat[0][0][0] = 8'h55;
    plen[0][0] = 1;
    exp_q.push_back(8'h55);
    rx0 = n_rx;
    send_pkt(0, 0);
    v[0] = 1'b0;
    w = 0;
    while (uart_tx !== 1'b0 && w < 20) begin
      @(negedge i_clk);
      w++;
    end
    check("single_frame_started", uart_tx, 0);
    s = cyc;
    repeat (10 * DIV - 1) @(negedge i_clk);
    check("busy_end_of_frame", busy, 1);
    @(negedge i_clk);
    check("busy_after_frame", busy, 0);
    check("level_after_frame", fifo_level, 0);
    check("single_frame_length", cyc - s, 10 * DIV);
    check("single_frame_decoded", n_rx, rx0 + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
